custom_sync_ptr_multi: RTL and testbench

Parametrised successor to the two-flop write-to-read pointer synchronizer. It carries a Gray-coded FIFO pointer across into the `clk_i` domain through a configurable number of flop stages, then provides:
- the synchronized Gray pointer and its binary equivalent;
- a per-cycle advance count;
- a sticky error flag for illegal multi-bit Gray transitions;
- a bank of toggle-to-pulse event channels.

It sits on the destination side of every async FIFO and CDC event path in the design.

---
 rtl/custom_sync_pkg.sv | 45 ++++
 rtl/custom_sync_ptr_multi_if.sv | 30 +++
 rtl/custom_sync_chain.sv | 31 +++
 rtl/custom_sync_ptr_multi.sv | 180 ++++++++++++++++++
 tb/tb_custom_sync_ptr_multi.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/custom_sync_pkg.sv
// Shared definitions for the multi-stage pointer/event synchronizer:
// depth limits, Gray/binary helpers, popcount and the warm-up state type.
package custom_sync_pkg;

    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 4;
    localparam int EVENTS_MIN = 1;
    localparam int EVENTS_MAX = 32;

    // Widest vector the helpers accept. Narrower values are zero-extended
    // by the caller. Leading zeros leave both Gray conversions and the
    // popcount unchanged, so one definition serves every width up to this.
    localparam int GRAY_MAX_W = 32;

    typedef enum logic [0:0] {
        WARM = 1'b0,
        RUN  = 1'b1
    } warm_state_e;

    // Gray to binary: each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Binary to Gray, mainly for stimulus generation.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Number of set bits.
    function automatic logic [5:0] popcount(input logic [GRAY_MAX_W-1:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/custom_sync_ptr_multi_if.sv
// Bundle of the source-side inputs and synchronized outputs of
// custom_sync_ptr_multi. The producer/bench side uses master, the block uses slave.
interface custom_sync_ptr_multi_if #(
    parameter int ADDRSIZE = 4,
    parameter int EVENTS   = 4
);

    logic [ADDRSIZE:0]   ptr_g_i;
    logic [EVENTS-1:0]   tog_i;
    logic                err_clr_i;

    logic [ADDRSIZE:0]   ptr_g_o;
    logic [ADDRSIZE:0]   ptr_b_o;
    logic [ADDRSIZE:0]   delta_o;
    logic                adv_o;
    logic                err_o;
    logic [EVENTS-1:0]   pulse_o;
    logic                ready_o;

    modport master (
        output ptr_g_i, tog_i, err_clr_i,
        input  ptr_g_o, ptr_b_o, delta_o, adv_o, err_o, pulse_o, ready_o
    );

    modport slave (
        input  ptr_g_i, tog_i, err_clr_i,
        output ptr_g_o, ptr_b_o, delta_o, adv_o, err_o, pulse_o, ready_o
    );

endinterface

// File: rtl/custom_sync_chain.sv
// Generic synchronous-reset flop chain used as a CDC synchronizer.
// The input goes straight into the first flop with no logic in front.
module custom_sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_r [STAGES];

    // Shift the sample one stage deeper every cycle; reset clears all stages.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign dout = stage_r[STAGES-1];

endmodule

// File: rtl/custom_sync_ptr_multi.sv
// Destination-side synchronizer for a Gray-coded FIFO pointer plus a bank
// of toggle-to-pulse event channels. Provides the synced pointer, its binary
// form, per-cycle advance, a sticky illegal-transition flag and a ready flag
// that stays low until the false jump out of reset has flushed through.
module custom_sync_ptr_multi
    import custom_sync_pkg::*;
#(
    parameter int ADDRSIZE = 4,
    parameter int STAGES   = 2,
    parameter int EVENTS   = 4
) (
    input logic                    clk_i,
    input logic                    rst_i,
    custom_sync_ptr_multi_if.slave bus
);

    localparam int PW    = ADDRSIZE + 1;
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(STAGES + 1);

    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("custom_sync_ptr_multi: STAGES=%0d outside %0d..%0d",
               STAGES, STAGES_MIN, STAGES_MAX);
    end
    if (EVENTS < EVENTS_MIN || EVENTS > EVENTS_MAX) begin : g_bad_events
        $error("custom_sync_ptr_multi: EVENTS=%0d outside %0d..%0d",
               EVENTS, EVENTS_MIN, EVENTS_MAX);
    end
    if (PW > GRAY_MAX_W) begin : g_bad_addrsize
        $error("custom_sync_ptr_multi: ADDRSIZE=%0d too wide", ADDRSIZE);
    end

    logic [PW-1:0]     ptr_sync_s;
    logic [EVENTS-1:0] tog_sync_s;

    warm_state_e       state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              ready_r;

    logic [PW-1:0]     ptr_b_r;
    logic [PW-1:0]     prev_g_r;
    logic [PW-1:0]     prev_b_r;
    logic [PW-1:0]     delta_r;
    logic              adv_r;
    logic              viol_r;
    logic              err_r;
    logic [EVENTS-1:0] tog_prev_r;
    logic [EVENTS-1:0] pulse_r;

    logic [PW-1:0]     diff_s;
    logic              run_s;
    logic              viol_s;
    logic              ev_en_s;
    logic [EVENTS-1:0] edge_s;

    custom_sync_chain #(
        .WIDTH  (PW),
        .STAGES (STAGES)
    ) u_ptr_chain (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .din   (bus.ptr_g_i),
        .dout  (ptr_sync_s)
    );

    custom_sync_chain #(
        .WIDTH  (EVENTS),
        .STAGES (STAGES)
    ) u_tog_chain (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .din   (bus.tog_i),
        .dout  (tog_sync_s)
    );

    // Delta, violation detect and event edge detect, gated by warm-up state.
    always_comb begin
        diff_s = ptr_b_r - prev_b_r;
        run_s  = (state_r == RUN);
        edge_s = tog_sync_s ^ tog_prev_r;
        if (run_s) begin
            viol_s = (popcount(GRAY_MAX_W'(ptr_sync_s ^ prev_g_r)) > 6'd1);
        end else begin
            viol_s = 1'b0;
        end
        // Events are live from the second cycle after reset onwards.
        if (run_s || (cnt_r != {CNT_W{1'b0}})) begin
            ev_en_s = 1'b1;
        end else begin
            ev_en_s = 1'b0;
        end
    end

    // Warm-up FSM: count out the pipeline fill after reset, then stay in RUN.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= WARM;
            cnt_r   <= {CNT_W{1'b0}};
            ready_r <= 1'b0;
        end else begin
            case (state_r)
                WARM: begin
                    if (cnt_r == WARM_LAST) begin
                        state_r <= RUN;
                        ready_r <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                RUN: begin
                    state_r <= RUN;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= WARM;
                    cnt_r   <= {CNT_W{1'b0}};
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Pointer datapath: binary conversion, history registers and advance count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_b_r  <= {PW{1'b0}};
            prev_g_r <= {PW{1'b0}};
            prev_b_r <= {PW{1'b0}};
            delta_r  <= {PW{1'b0}};
            adv_r    <= 1'b0;
        end else begin
            ptr_b_r  <= PW'(gray2bin(GRAY_MAX_W'(ptr_sync_s)));
            prev_g_r <= ptr_sync_s;
            prev_b_r <= ptr_b_r;
            if (run_s) begin
                delta_r <= diff_s;
                adv_r   <= (diff_s != {PW{1'b0}});
            end else begin
                delta_r <= {PW{1'b0}};
                adv_r   <= 1'b0;
            end
        end
    end

    // Sticky error flag. The violation is staged once so err_o reports in the
    // same cycle as delta_o for the same sample pair; a new violation beats clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            viol_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            viol_r <= viol_s;
            err_r  <= viol_r | (err_r & ~bus.err_clr_i);
        end
    end

    // Event channels: one registered pulse per synced toggle edge, either polarity.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tog_prev_r <= {EVENTS{1'b0}};
            pulse_r    <= {EVENTS{1'b0}};
        end else begin
            tog_prev_r <= tog_sync_s;
            if (ev_en_s) begin
                pulse_r <= edge_s;
            end else begin
                pulse_r <= {EVENTS{1'b0}};
            end
        end
    end

    assign bus.ptr_g_o = ptr_sync_s;
    assign bus.ptr_b_o = ptr_b_r;
    assign bus.delta_o = delta_r;
    assign bus.adv_o   = adv_r;
    assign bus.err_o   = err_r;
    assign bus.pulse_o = pulse_r;
    assign bus.ready_o = ready_r;

endmodule

// File: tb/tb_custom_sync_ptr_multi.sv
// Scoreboard bench for custom_sync_ptr_multi (ADDRSIZE=4, STAGES=2, EVENTS=4).
// Each stimulus step pushes its expected outputs with the cycle they are due;
// a negedge monitor pops and compares whatever is due in the current cycle.
module tb_custom_sync_ptr_multi;
    import custom_sync_pkg::*;

    localparam int A  = 4;
    localparam int S  = 2;
    localparam int E  = 4;
    localparam int PW = A + 1;

    typedef enum int {O_PTR_G, O_PTR_B, O_DELTA, O_ADV, O_ERR, O_PULSE, O_READY} out_sel_e;

    typedef struct {
        int          due;
        out_sel_e    sel;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t          sb_q[$];
    int            chk_cnt  = 0;
    int            fail_cnt = 0;
    int            cyc      = 0;
    logic          clk      = 1'b0;
    logic          rst;
    logic [PW-1:0] cur_b;

    custom_sync_ptr_multi_if #(.ADDRSIZE(A), .EVENTS(E)) bus_if ();

    custom_sync_ptr_multi #(
        .ADDRSIZE (A),
        .STAGES   (S),
        .EVENTS   (E)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] peek(input out_sel_e s);
        case (s)
            O_PTR_G: return 32'(bus_if.ptr_g_o);
            O_PTR_B: return 32'(bus_if.ptr_b_o);
            O_DELTA: return 32'(bus_if.delta_o);
            O_ADV:   return 32'(bus_if.adv_o);
            O_ERR:   return 32'(bus_if.err_o);
            O_PULSE: return 32'(bus_if.pulse_o);
            O_READY: return 32'(bus_if.ready_o);
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic push_exp(input int due, input out_sel_e sel, input logic [31:0] v, input string tag);
        exp_t e;
        e.due = due;
        e.sel = sel;
        e.exp = v;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic push_idle(input int due, input string tag);
        push_exp(due, O_PTR_G, 32'd0, {tag, "_ptr_g"});
        push_exp(due, O_PTR_B, 32'd0, {tag, "_ptr_b"});
        push_exp(due, O_DELTA, 32'd0, {tag, "_delta"});
        push_exp(due, O_ADV,   32'd0, {tag, "_adv"});
        push_exp(due, O_ERR,   32'd0, {tag, "_err"});
        push_exp(due, O_PULSE, 32'd0, {tag, "_pulse"});
        push_exp(due, O_READY, 32'd0, {tag, "_ready"});
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a new source pointer and queue its expected downstream effects.
    task automatic drive_ptr(input logic [PW-1:0] g, input logic [PW-1:0] b,
                             input logic e, input string tag);
        logic [PW-1:0] d;
        d = b - cur_b;
        bus_if.ptr_g_i = g;
        push_exp(cyc + S,     O_PTR_G, 32'(g),       {tag, "_ptr_g"});
        push_exp(cyc + S + 1, O_PTR_B, 32'(b),       {tag, "_ptr_b"});
        push_exp(cyc + S + 2, O_DELTA, 32'(d),       {tag, "_delta"});
        push_exp(cyc + S + 2, O_ADV,   32'(d != '0), {tag, "_adv"});
        push_exp(cyc + S + 3, O_ADV,   32'd0,        {tag, "_adv_1cyc"});
        push_exp(cyc + S + 2, O_ERR,   32'(e),       {tag, "_err"});
        cur_b = b;
    endtask

    task automatic push_warm(input int r, input logic [PW-1:0] g, input logic [PW-1:0] b, input string tag);
        push_exp(r + 1,     O_PTR_G, 32'd0, {tag, "_ptr_g_early"});
        push_exp(r + S,     O_PTR_G, 32'(g), {tag, "_ptr_g"});
        push_exp(r + S,     O_PTR_B, 32'd0, {tag, "_ptr_b_early"});
        push_exp(r + S + 1, O_PTR_B, 32'(b), {tag, "_ptr_b"});
        push_exp(r + S + 1, O_READY, 32'd0, {tag, "_ready_early"});
        push_exp(r + S + 2, O_READY, 32'd1, {tag, "_ready"});
        for (int k = 1; k <= S + 5; k++) begin
            push_exp(r + k, O_ERR, 32'd0, {tag, "_no_err"});
        end
        for (int k = S + 2; k <= S + 3; k++) begin
            push_exp(r + k, O_DELTA, 32'd0, {tag, "_no_jump_delta"});
            push_exp(r + k, O_ADV,   32'd0, {tag, "_no_jump_adv"});
        end
    endtask

    // Compare every expectation that falls due in this cycle.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due == cyc) begin
                check_val(sb_q[i].tag, peek(sb_q[i].sel), sb_q[i].exp);
                sb_q.delete(i);
            end
        end
    end

    initial begin
        int c;
        int r;
        logic [PW-1:0] b;

        rst              = 1'b1;
        bus_if.ptr_g_i   = '0;
        bus_if.tog_i     = '0;
        bus_if.err_clr_i = 1'b0;
        cur_b            = '0;

        // Reset held for three edges: everything reads zero.
        for (int d = 1; d <= 3; d++) push_idle(d, "rst");
        wait_cyc(3);

        // Release with a live pointer of binary 8.
        rst            = 1'b0;
        bus_if.ptr_g_i = 5'b01100;
        cur_b          = 5'd8;
        r              = cyc;
        push_warm(r, 5'b01100, 5'd8, "warm");
        for (int k = 1; k <= S + 2; k++) push_exp(r + k, O_PULSE, 32'd0, "warm_pulse");
        wait_cyc(7);

        // Events: tog[0] and tog[2] together, then tog[0] back 5 cycles later.
        bus_if.tog_i = 4'b0101;
        c = cyc;
        push_exp(c + S,     O_PULSE, 32'd0,     "ev1_pre");
        push_exp(c + S + 1, O_PULSE, 32'h5,     "ev1_pulse");
        push_exp(c + S + 2, O_PULSE, 32'd0,     "ev1_post");
        wait_cyc(5);
        bus_if.tog_i = 4'b0100;
        c = cyc;
        push_exp(c + S,     O_PULSE, 32'd0,     "ev2_pre");
        push_exp(c + S + 1, O_PULSE, 32'h1,     "ev2_pulse");
        push_exp(c + S + 2, O_PULSE, 32'd0,     "ev2_post");
        wait_cyc(5);

        // Single steps 9..31, wrap through 0, up to 3.
        for (int i = 9; i <= 35; i++) begin
            b = PW'(i);
            drive_ptr(PW'(bin2gray(32'(b))), b, 1'b0, $sformatf("step%0d", i % 32));
            wait_cyc(4);
        end

        // Illegal 3-bit Gray jump 3 -> 6: error sets and sticks, clear drops it.
        drive_ptr(5'b00101, 5'd6, 1'b1, "illegal");
        c = cyc;
        for (int k = S + 3; k <= S + 5; k++) push_exp(c + k, O_ERR, 32'd1, "err_sticky");
        wait_cyc(8);
        push_exp(cyc, O_ERR, 32'd1, "err_before_clr");
        bus_if.err_clr_i = 1'b1;
        wait_cyc(1);
        bus_if.err_clr_i = 1'b0;
        push_exp(cyc,     O_ERR, 32'd0, "err_clr");
        push_exp(cyc + 1, O_ERR, 32'd0, "err_clr_hold");
        wait_cyc(3);

        // Back down to 4, then a multi-step advance 4 -> 7.
        drive_ptr(PW'(bin2gray(32'd5)), 5'd5, 1'b0, "down5");
        wait_cyc(4);
        drive_ptr(PW'(bin2gray(32'd4)), 5'd4, 1'b0, "down4");
        wait_cyc(4);
        drive_ptr(PW'(bin2gray(32'd7)), 5'd7, 1'b0, "multi");
        wait_cyc(6);

        // Illegal jump 7 -> 13, then reset while err_o and adv_o are high.
        drive_ptr(PW'(bin2gray(32'd13)), 5'd13, 1'b1, "pre_rst");
        wait_cyc(S + 2);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        r   = cyc;
        push_idle(r, "midrst");
        push_warm(r, PW'(bin2gray(32'd13)), 5'd13, "rewarm");
        wait_cyc(12);

        check_val("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
        $finish;
    end

endmodule
